// File: rtl/mii_frame_generator_if.sv
// Request and transmit bus of the MII/XGMII test-frame generator.
// The master drives frame requests; the slave drives the transmit words.
interface mii_frame_generator_if;
    logic        i_start;
    logic [7:0]  i_payload_len;
    logic [5:0]  i_ipg_len;
    logic [7:0]  i_seed;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frame_count;

    modport master (
        output i_start,
        output i_payload_len,
        output i_ipg_len,
        output i_seed,
        input  o_tx_data,
        input  o_tx_ctrl,
        input  o_busy,
        input  o_done,
        input  o_frame_count
    );

    modport slave (
        input  i_start,
        input  i_payload_len,
        input  i_ipg_len,
        input  i_seed,
        output o_tx_data,
        output o_tx_ctrl,
        output o_busy,
        output o_done,
        output o_frame_count
    );
endinterface

// File: rtl/mii_frame_generator.sv
// 64-bit XGMII-style frame generator: START, incrementing payload,
// TERM and inter-packet gap, with registered tx words.
module mii_frame_generator (
    input  logic                 clk,
    input  logic                 i_rst,
    mii_frame_generator_if.slave bus
);

    localparam int          DATA_WIDTH = 64;
    localparam int          CTRL_WIDTH = 8;
    localparam logic [7:0]  IDLE_CODE  = 8'h07;
    localparam logic [7:0]  START_CODE = 8'hFB;
    localparam logic [7:0]  TERM_CODE  = 8'hFD;
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_CODE}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_TERM,
        S_IPG
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] w_tx_data_nx;
    logic [CTRL_WIDTH-1:0] r_tx_ctrl;
    logic [CTRL_WIDTH-1:0] w_tx_ctrl_nx;
    logic                  r_done;
    logic                  w_done_nx;
    logic [15:0]           r_count;
    logic [15:0]           w_count_nx;
    logic [7:0]            r_rem;
    logic [7:0]            w_rem_nx;
    logic [7:0]            r_byte;
    logic [7:0]            w_byte_nx;
    logic [5:0]            r_ipg;
    logic [5:0]            w_ipg_nx;
    logic [6:0]            r_idle;
    logic [6:0]            w_idle_nx;

    logic [7:0]            w_len;
    logic [2:0]            w_rem3;
    logic [6:0]            w_ipg7;
    logic [6:0]            w_term_idle;
    logic [6:0]            w_ipg_idle;
    logic [DATA_WIDTH-1:0] w_seed_lanes;
    logic [DATA_WIDTH-1:0] w_cur_lanes;
    logic [DATA_WIDTH-1:0] w_term_data;
    logic [CTRL_WIDTH-1:0] w_term_ctrl;

    // Eight consecutive payload bytes starting at base, lane 0 first.
    function automatic logic [DATA_WIDTH-1:0] f_lanes(input logic [7:0] base);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int n = 0; n < CTRL_WIDTH; n++) begin
            v[8*n +: 8] = base + 8'(n);
        end
        return v;
    endfunction

    assign w_len        = (bus.i_payload_len < 8'd7) ? 8'd7 : bus.i_payload_len;
    assign w_rem3       = r_rem[2:0];
    assign w_ipg7       = {1'b0, r_ipg};
    assign w_term_idle  = 7'd7 - {4'd0, w_rem3};
    assign w_ipg_idle   = r_idle + 7'd8;
    assign w_seed_lanes = f_lanes(bus.i_seed);
    assign w_cur_lanes  = f_lanes(r_byte);

    // Tail word: rem payload bytes, then TERM, then idles.
    always_comb begin
        w_term_data = IDLE_WORD;
        w_term_ctrl = '1;
        for (int n = 0; n < CTRL_WIDTH; n++) begin
            if (3'(n) < w_rem3) begin
                w_term_data[8*n +: 8] = w_cur_lanes[8*n +: 8];
                w_term_ctrl[n]        = 1'b0;
            end else if (3'(n) == w_rem3) begin
                w_term_data[8*n +: 8] = TERM_CODE;
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_tx_data_nx = IDLE_WORD;
        w_tx_ctrl_nx = '1;
        w_done_nx    = 1'b0;
        w_count_nx   = r_count;
        w_rem_nx     = r_rem;
        w_byte_nx    = r_byte;
        w_ipg_nx     = r_ipg;
        w_idle_nx    = r_idle;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nx   = S_START;
                    w_tx_data_nx = {w_seed_lanes[55:0], START_CODE};
                    w_tx_ctrl_nx = 8'h01;
                    w_rem_nx     = w_len - 8'd7;
                    w_byte_nx    = bus.i_seed + 8'd7;
                    w_ipg_nx     = bus.i_ipg_len;
                    w_idle_nx    = '0;
                end
            end
            S_START, S_DATA: begin
                if (r_rem >= 8'd8) begin
                    w_state_nx   = S_DATA;
                    w_tx_data_nx = w_cur_lanes;
                    w_tx_ctrl_nx = '0;
                    w_rem_nx     = r_rem - 8'd8;
                    w_byte_nx    = r_byte + 8'd8;
                end else begin
                    w_state_nx   = S_TERM;
                    w_tx_data_nx = w_term_data;
                    w_tx_ctrl_nx = w_term_ctrl;
                    w_idle_nx    = w_term_idle;
                    w_count_nx   = r_count + 16'd1;
                    w_done_nx    = (w_term_idle >= w_ipg7);
                end
            end
            S_TERM, S_IPG: begin
                if (r_idle >= w_ipg7) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_IPG;
                    w_idle_nx  = w_ipg_idle;
                    w_done_nx  = (w_ipg_idle >= w_ipg7);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tx_data <= IDLE_WORD;
            r_tx_ctrl <= '1;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_rem     <= '0;
            r_byte    <= '0;
            r_ipg     <= '0;
            r_idle    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_tx_data <= w_tx_data_nx;
            r_tx_ctrl <= w_tx_ctrl_nx;
            r_done    <= w_done_nx;
            r_count   <= w_count_nx;
            r_rem     <= w_rem_nx;
            r_byte    <= w_byte_nx;
            r_ipg     <= w_ipg_nx;
            r_idle    <= w_idle_nx;
        end
    end

    assign bus.o_tx_data     = r_tx_data;
    assign bus.o_tx_ctrl     = r_tx_ctrl;
    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_done        = r_done;
    assign bus.o_frame_count = r_count;

endmodule

// File: tb/tb_mii_frame_generator.sv
// Bench for mii_frame_generator: a byte-stream model of each frame is
// chunked into expected 64-bit words and compared cycle by cycle.
module tb_mii_frame_generator;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;

    logic clk = 1'b0;
    logic i_rst;

    mii_frame_generator_if bus();

    mii_frame_generator dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count = '0;
    logic [63:0] exp_d[$];
    logic [7:0]  exp_c[$];

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte stream: START, payload, TERM, idles to word end, then whole
    // idle words until the idles after TERM reach the gap.
    task automatic build(input int len, input int ipg, input logic [7:0] seed);
        logic [7:0] b[$];
        bit         c[$];
        int         le;
        int         idle;
        logic [7:0] v;
        logic [63:0] d;
        logic [7:0]  cw;
        le = (len < 7) ? 7 : len;
        b.push_back(8'hFB); c.push_back(1'b1);
        for (int k = 0; k < le; k++) begin
            v = seed + 8'(k);
            b.push_back(v); c.push_back(1'b0);
        end
        b.push_back(8'hFD); c.push_back(1'b1);
        idle = 0;
        while (b.size() % 8 != 0) begin
            b.push_back(8'h07); c.push_back(1'b1); idle++;
        end
        while (idle < ipg) begin
            for (int k = 0; k < 8; k++) begin
                b.push_back(8'h07); c.push_back(1'b1);
            end
            idle += 8;
        end
        exp_d.delete();
        exp_c.delete();
        for (int w = 0; w < b.size() / 8; w++) begin
            for (int n = 0; n < 8; n++) begin
                d[8*n +: 8] = b[8*w + n];
                cw[n]       = c[8*w + n];
            end
            exp_d.push_back(d);
            exp_c.push_back(cw);
        end
    endtask

    task automatic scramble();
        bus.i_start       = 1'($urandom);
        bus.i_payload_len = 8'($urandom);
        bus.i_ipg_len     = 6'($urandom);
        bus.i_seed        = 8'($urandom);
    endtask

    task automatic run_frame(input int len, input int ipg,
                             input logic [7:0] seed, input bit hold,
                             input string tag);
        int nw;
        build(len, ipg, seed);
        nw = exp_d.size();
        bus.i_start       = 1'b1;
        bus.i_payload_len = 8'(len);
        bus.i_ipg_len     = 6'(ipg);
        bus.i_seed        = seed;
        for (int w = 0; w < nw; w++) begin
            @(posedge clk); #1;
            if (!hold) scramble();
            chk($sformatf("%s_w%0d", tag, w),
                {22'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy},
                {22'd0, exp_d[w], exp_c[w], (w == nw - 1), 1'b1});
        end
        exp_count++;
        if (!hold) bus.i_start = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_idle", tag),
            {6'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy,
             bus.o_frame_count},
            {6'd0, IDLE_W, 8'hFF, 1'b0, 1'b0, exp_count});
        if (!hold) begin
            @(posedge clk); #1;
            chk($sformatf("%s_gap", tag),
                {22'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy},
                {22'd0, IDLE_W, 8'hFF, 1'b0, 1'b0});
        end
    endtask

    initial begin
        i_rst             = 1'b1;
        bus.i_start       = 1'b1;
        bus.i_payload_len = 8'd46;
        bus.i_ipg_len     = 6'd12;
        bus.i_seed        = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        chk("reset",
            {6'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy,
             bus.o_frame_count},
            {6'd0, IDLE_W, 8'hFF, 1'b0, 1'b0, 16'd0});
        bus.i_start = 1'b0;
        #3 i_rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start",
            {22'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy},
            {22'd0, IDLE_W, 8'hFF, 1'b0, 1'b0});

        run_frame(46, 12, 8'h00, 1'b0, "l46");
        run_frame(7, 0, 8'h10, 1'b0, "l7_ipg0");
        run_frame(3, 0, 8'h10, 1'b0, "l3");
        run_frame(0, 5, 8'hAA, 1'b0, "l0");
        run_frame(255, 12, 8'hF0, 1'b0, "l255");
        run_frame(8, 63, 8'h33, 1'b0, "l8_ipg63");
        run_frame(14, 7, 8'hFE, 1'b0, "l14");
        run_frame(15, 8, 8'h01, 1'b0, "l15");

        run_frame(46, 12, 8'h00, 1'b1, "b2b0");
        run_frame(46, 12, 8'h00, 1'b1, "b2b1");
        run_frame(46, 12, 8'h00, 1'b0, "b2b2");

        // Reset while the second DATA word is on the bus.
        build(46, 12, 8'h00);
        bus.i_start       = 1'b1;
        bus.i_payload_len = 8'd46;
        bus.i_ipg_len     = 6'd12;
        bus.i_seed        = 8'h00;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_data2",
            {24'd0, bus.o_tx_data, bus.o_tx_ctrl},
            {24'd0, exp_d[2], exp_c[2]});
        #1 i_rst = 1'b1;
        #1;
        chk("rst_async",
            {6'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy,
             bus.o_frame_count},
            {6'd0, IDLE_W, 8'hFF, 1'b0, 1'b0, 16'd0});
        exp_count = '0;
        #2 i_rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_term",
            {22'd0, bus.o_tx_data, bus.o_tx_ctrl, bus.o_done, bus.o_busy},
            {22'd0, IDLE_W, 8'hFF, 1'b0, 1'b0});
        run_frame(46, 12, 8'h00, 1'b0, "after_rst");

        for (int i = 0; i < 12; i++) begin
            run_frame(int'($urandom_range(46, 150)), int'($urandom_range(12, 32)),
                      8'($urandom), 1'b0, $sformatf("lb%0d", i));
        end
        for (int i = 0; i < 12; i++) begin
            run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                      8'($urandom), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mii_frame_generator.md
MII_FRAME_GENERATOR -- requirements
Module: mii_frame_generator

Interface
REQ-001 DATA_WIDTH, 64, tx data bus width; 8 byte lanes, lane n = bits [8n+7:8n].
REQ-002 CTRL_WIDTH, 8, control bits; one per lane.
REQ-003 IDLE_CODE, 8'h07, idle control character.
REQ-004 START_CODE, 8'hFB, start control character.
REQ-005 TERM_CODE, 8'hFD, terminate control character.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 i_rst  in  1  reset; asynchronous, active-high.
REQ-008 i_start  in  1  frame request; sampled only in state IDLE.
REQ-009 i_payload_len  in  8  payload bytes; values 0-6 treated as 7.
REQ-010 i_ipg_len  in  6  minimum idle bytes after TERM_CODE.
REQ-011 i_seed  in  8  value of payload byte 0.
REQ-012 o_tx_data  out  64  registered tx data.
REQ-013 o_tx_ctrl  out  8  registered tx control; bit n=1 marks lane n as a control character.
REQ-014 o_busy  out  1  high while state is not IDLE.
REQ-015 o_done  out  1  one-cycle pulse with the last word of a frame.
REQ-016 o_frame_count  out  16  frames sent, wraps at 16'hFFFF->0.

Function
REQ-017 States: IDLE, START, DATA, TERM, IPG; o_tx_data/o_tx_ctrl SHALL be registered.
REQ-018 IDLE: drive all lanes IDLE_CODE, ctrl 8'hFF; on i_start=1 latch L=max(i_payload_len,7), ipg, seed; go to START.
REQ-019 Payload byte k value SHALL be (seed+k) mod 256, k=0..L-1, in ascending lane order.
REQ-020 START word: lane0 START_CODE, lanes1-7 bytes 0-6, ctrl 8'h01; rem=L-7; next DATA if rem>=8, else TERM.
REQ-021 DATA word: 8 payload bytes, ctrl 8'h00; rem-=8; stay DATA while new rem>=8, else TERM.
REQ-022 TERM word: lanes 0..rem-1 payload, lane rem TERM_CODE, lanes rem+1..7 IDLE_CODE, ctrl = (8'hFF<<rem) truncated to 8 bits; idle_cnt=7-rem.
REQ-023 After TERM: if idle_cnt>=ipg go IDLE, else IPG.
REQ-024 IPG word: all IDLE_CODE, ctrl 8'hFF; idle_cnt+=8; go IDLE when new idle_cnt>=ipg.
REQ-025 Start word SHALL appear on the outputs the cycle after i_start is sampled in IDLE; i_start in any other state SHALL be ignored, not queued.
REQ-026 o_done SHALL be high with the TERM word if no IPG words follow, otherwise with the last IPG word.
REQ-027 o_frame_count SHALL increment once per TERM word.
REQ-028 At least one IDLE-state idle word SHALL separate back-to-back frames, so the effective gap is >= ipg+8 idle bytes.
REQ-029 Latched L/ipg/seed SHALL NOT change mid-frame when inputs change.
REQ-030 rem==0 in TERM (L-7 a multiple of 8) SHALL put TERM_CODE in lane0 with ctrl 8'hFF.

Reset
REQ-031 i_rst=1 SHALL immediately force state IDLE, o_tx_data 64'h0707070707070707, o_tx_ctrl 8'hFF, o_busy 0, o_done 0, o_frame_count 0, internal counters 0.
REQ-032 Reset mid-frame SHALL abort the frame without emitting TERM_CODE; the next i_start after release SHALL begin a fresh frame.

Verification
REQ-033 L=46, seed=0, ipg=12 -> START(lanes1-7=00..06, ctrl 01), 4 DATA (07..26), TERM(27..2D, FD lane7, ctrl 80), 2 IPG words with o_done on the second, count=1.
REQ-034 L=7, ipg=0 -> START then TERM with FD lane0, ctrl FF, o_done with TERM, no IPG word.
REQ-035 L=3 -> identical output to L=7; L=255, seed=F0 -> payload bytes wrap F0..FF,00..EE, 31 DATA words, TERM rem=0.
REQ-036 i_start held high continuously with L=46, ipg=12 -> frames repeat with exactly one IDLE word between the last IPG word and the next START.
REQ-037 Assert i_rst during the second DATA word -> idle word and ctrl FF in the same cycle, o_busy 0; the next frame is correct from byte 0.
REQ-038 Loopback into the existing MII checker with L=46..150, ipg=12..32 -> no payload, intergap or idle errors, and captured words match the generated words.
